// File: rtl/lsm_seq_engine_pkg.sv
// Shared encodings for the load/store-multiple sequencer: FSM states,
// transfer direction constants and the latched transfer mode.
package lsm_seq_engine_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef struct packed {
        logic is_load;
        logic descend;
    } lsm_mode_t;

endpackage

// File: rtl/lsm_seq_engine_if.sv
// Bundle of control, memory-port and register-file signals around the sequencer.
// The slave modport is the engine's view; master is the surrounding system.
interface lsm_seq_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = 3
);
    logic              start;
    logic              is_load;
    logic              descend;
    logic [ADDR_W-1:0] base_addr;
    logic [NREGS-1:0]  reg_mask;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] final_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [IDX_W-1:0]  rf_idx;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wr_data;

    modport slave (
        input  start, is_load, descend, base_addr, reg_mask,
        input  mem_rdata, mem_ready, rf_rd_data,
        output busy, done, final_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output rf_idx, rf_we, rf_wr_data
    );

    modport master (
        output start, is_load, descend, base_addr, reg_mask,
        output mem_rdata, mem_ready, rf_rd_data,
        input  busy, done, final_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_idx, rf_we, rf_wr_data
    );

endinterface

// File: rtl/lsm_seq_engine_prio_enc.sv
// Register-mask priority encoder: lowest set bit when ascending, highest when
// descending. Purely combinational so the decoder can reuse it for legality checks.
module lsm_prio_enc #(
    parameter int NREGS = 8,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic [NREGS-1:0] mask_i,
    input  logic             descend_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    import lsm_seq_engine_pkg::*;

    always_comb begin
        idx_o   = '0;
        valid_o = |mask_i;
        // Later loop iterations win, so scan order picks the priority end.
        if (descend_i == DIR_DOWN) begin
            for (int i = 0; i < NREGS; i++) begin
                if (mask_i[i]) idx_o = IDX_W'(i);
            end
        end else begin
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (mask_i[i]) idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lsm_seq_engine.sv
// Load-multiple / store-multiple sequencer: walks a register mask and issues one
// memory access per set bit, stalling on mem_ready, then pulses done.
module lsm_seq_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    lsm_seq_engine_if.slave   bus
);
    import lsm_seq_engine_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [NREGS-1:0]  mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] final_q;
    lsm_mode_t         mode_q, mode_d;

    logic [IDX_W-1:0]  cur_idx;
    logic              cur_valid;
    logic [NREGS-1:0]  cur_bit;
    logic              xfer;

    lsm_prio_enc #(.NREGS(NREGS), .IDX_W(IDX_W)) u_prio_enc (
        .mask_i    (mask_q),
        .descend_i (mode_q.descend),
        .idx_o     (cur_idx),
        .valid_o   (cur_valid)
    );

    assign xfer = (state_q == ST_XFER);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        cur_bit = '0;
        cur_bit[cur_idx] = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d.is_load = bus.is_load;
                    mode_d.descend = bus.descend;
                    mask_d         = bus.reg_mask;
                    addr_d         = bus.base_addr;
                    state_d        = (bus.reg_mask == '0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (bus.mem_ready && cur_valid) begin
                    mask_d = mask_q & ~cur_bit;
                    // Address arithmetic wraps naturally modulo 2^ADDR_W.
                    addr_d = (mode_q.descend == DIR_DOWN) ? addr_q - 1'b1 : addr_q + 1'b1;
                    if (mask_d == '0) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            // Load on DONE entry so the value is valid during the done pulse.
            if (state_d == ST_DONE) final_q <= addr_d;
        end
    end

    // Data outputs are gated to zero outside XFER so an abort leaves a quiet bus.
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.final_addr = final_q;
    assign bus.mem_req    = xfer;
    assign bus.mem_we     = xfer & ~mode_q.is_load;
    assign bus.mem_addr   = xfer ? addr_q : '0;
    assign bus.mem_wdata  = xfer ? bus.rf_rd_data : '0;
    assign bus.rf_idx     = xfer ? cur_idx : '0;
    assign bus.rf_we      = xfer & mode_q.is_load & bus.mem_ready;
    assign bus.rf_wr_data = xfer ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_lsm_seq_engine.sv
// Directed bench for lsm_seq_engine: cycle-accurate LM/SM walks, stalls, address
// wrap, empty mask, mid-transfer reset and a 16-register instance.
module tb_lsm_seq_engine;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    lsm_seq_engine_if #(.DATA_W(16), .ADDR_W(16), .NREGS(8),  .IDX_W(3)) ifc ();
    lsm_seq_engine_if #(.DATA_W(16), .ADDR_W(16), .NREGS(16), .IDX_W(4)) ifc16 ();

    lsm_seq_engine #(.DATA_W(16), .ADDR_W(16), .NREGS(8), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc)
    );

    lsm_seq_engine #(.DATA_W(16), .ADDR_W(16), .NREGS(16), .IDX_W(4)) dut16 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc16)
    );

    // Register-file models: each register reads back a recognisable value.
    assign ifc.rf_rd_data   = 16'hA000 + 16'(ifc.rf_idx);
    assign ifc16.rf_rd_data = 16'hB000 + 16'(ifc16.rf_idx);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Runs one transfer on the 8-register DUT, stepping cycle by cycle from start.
    // exp_q holds the expected register order; stall_len cycles of mem_ready=0
    // precede transfer number stall_at. Start is held high with junk operands
    // throughout the transfer to show the latched values are unaffected.
    task automatic run8(input logic ld, input logic desc, input logic [15:0] base,
                        input logic [7:0] mask, input int stall_at, input int stall_len,
                        input logic [15:0] exp_final);
        logic [15:0] ea;
        int idx;
        ea = base;
        @(negedge clk);
        ifc.start = 1'b1; ifc.is_load = ld; ifc.descend = desc;
        ifc.base_addr = base; ifc.reg_mask = mask; ifc.mem_ready = 1'b1;
        #1 chk("start_busy", ifc.busy, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            idx = exp_q[k];
            for (int s = 0; s < ((k == stall_at) ? stall_len : 0); s++) begin
                @(negedge clk);
                ifc.is_load = ~ld; ifc.descend = ~desc;
                ifc.base_addr = 16'hDEAD; ifc.reg_mask = 8'hFF;
                ifc.mem_ready = 1'b0; ifc.mem_rdata = 16'h5555;
                #1;
                chk("stall_req",  ifc.mem_req,  1);
                chk("stall_addr", ifc.mem_addr, ea);
                chk("stall_idx",  ifc.rf_idx,   idx);
                chk("stall_rfwe", ifc.rf_we,    0);
                chk("stall_memwe", ifc.mem_we,  !ld);
            end
            @(negedge clk);
            ifc.is_load = ~ld; ifc.descend = ~desc;
            ifc.base_addr = 16'hDEAD; ifc.reg_mask = 8'hFF;
            ifc.mem_ready = 1'b1; ifc.mem_rdata = 16'hC000 + 16'(k);
            #1;
            chk("req",   ifc.mem_req,  1);
            chk("addr",  ifc.mem_addr, ea);
            chk("idx",   ifc.rf_idx,   idx);
            chk("busy",  ifc.busy,     1);
            chk("rf_we", ifc.rf_we,    ld);
            chk("mem_we", ifc.mem_we,  !ld);
            if (ld) chk("rf_wr_data", ifc.rf_wr_data, 16'hC000 + 16'(k));
            else    chk("mem_wdata",  ifc.mem_wdata,  16'hA000 + 16'(idx));
            chk("done_early", ifc.done, 0);
            ea = desc ? ea - 16'd1 : ea + 16'd1;
        end
        @(negedge clk);
        ifc.start = 1'b0; ifc.mem_ready = 1'b0;
        #1;
        chk("done",       ifc.done,       1);
        chk("done_busy",  ifc.busy,       1);
        chk("done_req",   ifc.mem_req,    0);
        chk("done_rfwe",  ifc.rf_we,      0);
        chk("final_addr", ifc.final_addr, exp_final);
        @(negedge clk);
        #1;
        chk("post_done", ifc.done, 0);
        chk("post_busy", ifc.busy, 0);
        chk("final_hold", ifc.final_addr, exp_final);
    endtask

    initial begin
        rst_n = 1'b0;
        ifc.start = 0; ifc.is_load = 0; ifc.descend = 0; ifc.base_addr = 0;
        ifc.reg_mask = 0; ifc.mem_rdata = 0; ifc.mem_ready = 0;
        ifc16.start = 0; ifc16.is_load = 0; ifc16.descend = 0; ifc16.base_addr = 0;
        ifc16.reg_mask = 0; ifc16.mem_rdata = 0; ifc16.mem_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  ifc.busy,       0);
        chk("rst_done",  ifc.done,       0);
        chk("rst_req",   ifc.mem_req,    0);
        chk("rst_final", ifc.final_addr, 0);
        chk("rst_addr",  ifc.mem_addr,   0);
        rst_n = 1'b1;

        // LM ascending, four registers
        exp_q = '{0, 2, 5, 7};
        run8(1'b1, 1'b0, 16'h0040, 8'b1010_0101, 0, 0, 16'h0044);
        // SM descending
        exp_q = '{2, 1};
        run8(1'b0, 1'b1, 16'h0010, 8'b0000_0110, 0, 0, 16'h000E);
        // Empty mask: straight to done
        exp_q = {};
        run8(1'b1, 1'b0, 16'h1234, 8'h00, 0, 0, 16'h1234);
        // Three-cycle stall on the second access
        exp_q = '{0, 1, 3};
        run8(1'b1, 1'b0, 16'h0200, 8'b0000_1011, 1, 3, 16'h0203);
        // SM with stall on first access
        exp_q = '{6, 4};
        run8(1'b0, 1'b1, 16'h0300, 8'b0101_0000, 0, 2, 16'h02FE);
        // Wrap upward past 0xFFFF
        exp_q = '{0, 1};
        run8(1'b1, 1'b0, 16'hFFFF, 8'b0000_0011, 0, 0, 16'h0001);
        // Wrap downward past 0x0000
        exp_q = '{1, 0};
        run8(1'b0, 1'b1, 16'h0000, 8'b0000_0011, 0, 0, 16'hFFFE);

        // Reset mid-transfer after one of four accesses
        @(negedge clk);
        ifc.start = 1; ifc.is_load = 1; ifc.descend = 0;
        ifc.base_addr = 16'h0100; ifc.reg_mask = 8'h0F; ifc.mem_ready = 1;
        @(negedge clk);
        ifc.start = 0;
        #1 chk("abort_first_we", ifc.rf_we, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_req",   ifc.mem_req,  0);
        chk("abort_rfwe",  ifc.rf_we,    0);
        chk("abort_busy",  ifc.busy,     0);
        chk("abort_addr",  ifc.mem_addr, 0);
        @(negedge clk);
        #1;
        chk("abort_done",  ifc.done,       0);
        chk("abort_final", ifc.final_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("abort_idle", ifc.busy, 0);
        exp_q = '{0, 2, 5, 7};
        run8(1'b1, 1'b0, 16'h0040, 8'b1010_0101, 0, 0, 16'h0044);

        // 16-register instance: idx 0 then 15
        @(negedge clk);
        ifc16.start = 1; ifc16.is_load = 1; ifc16.descend = 0;
        ifc16.base_addr = 16'h0020; ifc16.reg_mask = 16'h8001;
        @(negedge clk);
        ifc16.start = 0;
        #1;
        chk("w16_idx0",  ifc16.rf_idx,   0);
        chk("w16_we0",   ifc16.rf_we,    1);
        chk("w16_addr0", ifc16.mem_addr, 16'h0020);
        @(negedge clk);
        #1;
        chk("w16_idx1",  ifc16.rf_idx,   15);
        chk("w16_addr1", ifc16.mem_addr, 16'h0021);
        @(negedge clk);
        #1;
        chk("w16_done",  ifc16.done,       1);
        chk("w16_final", ifc16.final_addr, 16'h0022);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
